output_accum_multibank: RTL and testbench
=========================================

// Module: output_accum_multibank
// PURPOSE
//  N-bank successor of the ping-pong output accumulator: accepts systolic partial sums one row/cycle
//  (valid/ready), accumulates across K-tiles with saturation, commits tiles into a FIFO of full banks
//  and drains them as packed INT8 beats (valid/ready) after ReLU + rounded requant. Sits between
//  systolic_array_sparse and the output DMA; scheduler drives row stream and tile_commit.
// PARAMETERS
//  N_ROWS     14  output-tile rows (row index range)
//  N_COLS     14  lanes per input row
//  ACC_W      32  signed accumulator width
//  OUT_W      8   signed output element width
//  NUM_BANKS  2   accumulator banks (>=2)
//  PACK       8   output elements per drain beat
// PORTS
//  clk          in   1               clock
//  rst          in   1               synchronous reset, active-high
//  in_valid     in   1               row valid
//  in_ready     out  1               row accepted when in_valid&in_ready
//  in_row       in   $clog2(N_ROWS)  target row of tile
//  in_first_k   in   1               1: overwrite row (first K-tile), 0: add
//  in_data      in   N_COLS*ACC_W    signed psums, lane c at [c*ACC_W +: ACC_W]
//  tile_commit  in   1               pulse: current ACC bank complete
//  relu_en      in   1               clamp negatives to 0 before scaling
//  scale_mult   in   16              unsigned multiplier
//  scale_shift  in   5               arithmetic right shift, round-half-up
//  out_valid    out  1               drain beat valid
//  out_ready    in   1               DMA accepts beat
//  out_data     out  PACK*OUT_W      element i at [i*OUT_W +: OUT_W], row-major
//  out_last     out  1               final beat of a bank
//  free_banks   out  $clog2(NUM_BANKS)+1  count of FREE banks
//  acc_ovf      out  1               sticky: accumulator saturated
//  commit_err   out  1               sticky: tile_commit with no ACC bank
// BEHAVIOUR
//  Reset: all banks FREE, wr/drain pointers 0, out_valid=0, out_last=0, out_data=0, stickies 0,
//   free_banks=NUM_BANKS; bank contents NOT cleared (first-K overwrite makes clear unnecessary).
//  Bank FSM each: FREE -> ACC (first accepted row while wr bank FREE) -> FULL (tile_commit)
//   -> DRAIN (drain engine selects it) -> FREE (out_last beat accepted). Banks used circularly.
//  in_ready = wr bank in FREE or ACC. Row write: 1 cycle; add = saturating signed ACC_W add,
//   saturation sets acc_ovf. in_row >= N_ROWS: row dropped, still handshaken.
//  tile_commit same cycle as accepted row: row included, then bank -> FULL, wr ptr advances.
//  tile_commit with wr bank not ACC: ignored, commit_err set.
//  Drain: oldest FULL bank in commit order; beats = ceil(N_ROWS*N_COLS/PACK); tail lanes beyond
//   N_ROWS*N_COLS output 0. Pipeline: read reg -> requant reg; first out_valid 2 cycles after
//   bank enters DRAIN. out_data/out_valid stable while out_valid&!out_ready (stall holds pipe,
//   no beat lost or duplicated). Back-to-back banks drain with no bubble.
//  Requant per lane: x = relu_en&&acc<0 ? 0 : acc; p = x*$signed({1'b0,scale_mult});
//   r = shift==0 ? p : (p + (1<<(shift-1))) >>> shift; saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//   scale_mult/scale_shift/relu_en sampled at the read stage; must be static per bank.
//  Same-bank read/write impossible by construction (ACC vs DRAIN states exclusive).
//  Reset mid-drain or mid-accumulate: immediate abort, state as reset; no partial beat issued.
// STRUCTURE
//  acc_pkg: bank_state_e {FREE,ACC,FULL,DRAIN}; sat_add and requant functions; width localparams.
//  Sub-module requant_lane (one element, registered), instantiated PACK times.
//  Banks: NUM_BANKS x N_ROWS row memories of N_COLS*ACC_W; row-wide write, PACK-wide read mux.
// TESTING
//  1 tile, 3 K-passes all-ones rows (first_k on pass 0), mult=1 shift=0 -> every element 3, 25 beats, last on 25th, tail lanes 0.
//  acc 0x7FFFFFF0 + 0x20 -> acc saturates 0x7FFFFFFF, acc_ovf=1; output 127.
//  acc -300,relu_en=1 -> 0; relu_en=0,mult=1,shift=1 -> -150 -> -128; acc 5,mult=1,shift=1 -> 3 (round-half-up).
//  NUM_BANKS=3, commit 3 tiles with out_ready=0 -> in_ready=0 after third, free_banks=0; release -> banks drain in commit order, free_banks back to 3.
//  Random out_ready toggling 50% -> beat stream identical to no-stall run, out_data stable across stalls.
//  tile_commit with no ACC bank -> commit_err=1, no state change; rst asserted mid-drain -> out_valid=0 next cycle, free_banks=NUM_BANKS.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared types, widths and arithmetic helpers for the multibank output accumulator.
package acc_pkg;

  localparam int ACC_W   = 32;
  localparam int OUT_W   = 8;
  localparam int MULT_W  = 16;
  localparam int SHIFT_W = 5;
  localparam int PROD_W  = ACC_W + MULT_W + 2;

  localparam logic signed [ACC_W-1:0]  ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0]  ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [PROD_W-1:0] Q_MAX   = PROD_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [PROD_W-1:0] Q_MIN   = PROD_W'(-(2 ** (OUT_W - 1)));

  typedef enum logic [1:0] {FREE, ACC, FULL, DRAIN} bank_state_e;

  // Overflow of a signed add shows up as disagreement between the two top bits of a widened sum.
  function automatic logic add_ovf(input logic signed [ACC_W-1:0] a,
                                   input logic signed [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    return s[ACC_W] ^ s[ACC_W-1];
  endfunction

  function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (s[ACC_W] ^ s[ACC_W-1]) begin
      return s[ACC_W] ? ACC_MIN : ACC_MAX;
    end
    return s[ACC_W-1:0];
  endfunction

  // Optional ReLU, unsigned scale, round-half-up arithmetic shift, then clamp to the output range.
  function automatic logic signed [OUT_W-1:0] requant(input logic signed [ACC_W-1:0] acc,
                                                      input logic                    relu,
                                                      input logic [MULT_W-1:0]       mult,
                                                      input logic [SHIFT_W-1:0]      shift);
    logic signed [ACC_W-1:0]  x;
    logic signed [PROD_W-1:0] p;
    logic signed [PROD_W-1:0] rnd;
    logic signed [PROD_W-1:0] r;
    x = (relu && acc < 0) ? '0 : acc;
    p = PROD_W'(x) * PROD_W'($signed({1'b0, mult}));
    if (shift == '0) begin
      r = p;
    end else begin
      rnd = PROD_W'(1) <<< (shift - SHIFT_W'(1));
      r   = (p + rnd) >>> shift;
    end
    if (r > Q_MAX) r = Q_MAX;
    if (r < Q_MIN) r = Q_MIN;
    return r[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/requant_lane.sv
// One output element: registered requantisation of a single accumulator value.
module requant_lane
  import acc_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic signed [ACC_W-1:0]  acc,
  input  logic                     relu_en,
  input  logic [MULT_W-1:0]        scale_mult,
  input  logic [SHIFT_W-1:0]       scale_shift,
  output logic signed [OUT_W-1:0]  q
);

  // Result only moves when the output stage advances, so a stalled beat stays put.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= requant(acc, relu_en, scale_mult, scale_shift);
    end
  end

endmodule

// File: rtl/output_accum_multibank.sv
// N-bank output accumulator: row-wise saturating accumulation into a circular set of banks,
// in-order drain of committed banks through a two-stage read/requant pipeline.
module output_accum_multibank
  import acc_pkg::*;
#(
  parameter int N_ROWS    = 14,
  parameter int N_COLS    = 14,
  parameter int NUM_BANKS = 2,
  parameter int PACK      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [$clog2(N_ROWS)-1:0]     in_row,
  input  logic                          in_first_k,
  input  logic [N_COLS*ACC_W-1:0]       in_data,
  input  logic                          tile_commit,
  input  logic                          relu_en,
  input  logic [MULT_W-1:0]             scale_mult,
  input  logic [SHIFT_W-1:0]            scale_shift,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [PACK*OUT_W-1:0]         out_data,
  output logic                          out_last,
  output logic [$clog2(NUM_BANKS):0]    free_banks,
  output logic                          acc_ovf,
  output logic                          commit_err
);

  localparam int TOTAL   = N_ROWS * N_COLS;
  localparam int BEATS   = (TOTAL + PACK - 1) / PACK;
  localparam int BANK_W  = $clog2(NUM_BANKS);
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int ELEM_AW = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int CNT_W   = $clog2(NUM_BANKS) + 1;

  logic signed [ACC_W-1:0] mem [NUM_BANKS][TOTAL];

  bank_state_e bank_q [NUM_BANKS];
  bank_state_e bank_d [NUM_BANKS];

  logic [BANK_W-1:0] wr_ptr;
  logic [BANK_W-1:0] drain_ptr;
  logic [BANK_W-1:0] drain_next;
  logic              reading;
  logic [BEAT_W-1:0] beat_cnt;

  logic                    rd_valid;
  logic                    rd_last;
  logic [BANK_W-1:0]       rd_bank;
  logic signed [ACC_W-1:0] rd_word [PACK];
  logic signed [ACC_W-1:0] rd_mux  [PACK];
  logic                    rd_relu;
  logic [MULT_W-1:0]       rd_mult;
  logic [SHIFT_W-1:0]      rd_shift;
  logic [BANK_W-1:0]       out_bank;

  logic signed [ACC_W-1:0] wr_row [N_COLS];
  logic                    wr_ovf;
  int                      row_base;
  logic                    accept, row_ok, wr_en, wr_eff_acc, commit_ok, commit_bad;
  logic                    out_can, rd_can, issue, issue_last, start, chain, release_bank;
  logic [CNT_W-1:0]        free_cnt;

  function automatic logic [BANK_W-1:0] next_ptr(input logic [BANK_W-1:0] p);
    return (p == BANK_W'(NUM_BANKS - 1)) ? '0 : p + BANK_W'(1);
  endfunction

  // Handshake, commit qualification and drain pipeline flow control.
  always_comb begin
    in_ready     = (bank_q[wr_ptr] == FREE) || (bank_q[wr_ptr] == ACC);
    accept       = in_valid && in_ready;
    row_ok       = int'(in_row) < N_ROWS;
    wr_en        = accept && row_ok;
    wr_eff_acc   = (bank_q[wr_ptr] == ACC) || (accept && bank_q[wr_ptr] == FREE);
    commit_ok    = tile_commit && wr_eff_acc;
    commit_bad   = tile_commit && !wr_eff_acc;
    out_can      = !out_valid || out_ready;
    rd_can       = !rd_valid || out_can;
    issue        = reading && rd_can;
    issue_last   = issue && (beat_cnt == BEAT_W'(BEATS - 1));
    drain_next   = next_ptr(drain_ptr);
    start        = !reading && (bank_q[drain_ptr] == FULL);
    chain        = issue_last && (bank_q[drain_next] == FULL);
    release_bank = out_valid && out_ready && out_last;
  end

  // Next bank states; each event targets a bank in a distinct current state, so they never collide.
  always_comb begin
    bank_d = bank_q;
    if (accept && bank_q[wr_ptr] == FREE) bank_d[wr_ptr] = ACC;
    if (commit_ok)                        bank_d[wr_ptr] = FULL;
    if (start)                            bank_d[drain_ptr] = DRAIN;
    if (chain)                            bank_d[drain_next] = DRAIN;
    if (release_bank)                     bank_d[out_bank] = FREE;
  end

  // Row merge: overwrite on the first K-tile, otherwise saturating add onto the stored row.
  always_comb begin
    wr_ovf   = 1'b0;
    row_base = row_ok ? int'(in_row) * N_COLS : 0;
    for (int c = 0; c < N_COLS; c++) begin
      logic signed [ACC_W-1:0] lane;
      logic signed [ACC_W-1:0] old;
      lane = $signed(in_data[c*ACC_W +: ACC_W]);
      old  = mem[wr_ptr][ELEM_AW'(row_base + c)];
      if (in_first_k) begin
        wr_row[c] = lane;
      end else begin
        wr_row[c] = sat_add(old, lane);
        wr_ovf    = wr_ovf | (wr_en & add_ovf(old, lane));
      end
    end
  end

  // PACK-wide read of the current drain beat; lanes past the tile end read as zero.
  always_comb begin
    for (int p = 0; p < PACK; p++) begin
      int e;
      e = int'(beat_cnt) * PACK + p;
      rd_mux[p] = (e < TOTAL) ? mem[drain_ptr][ELEM_AW'(e)] : '0;
    end
  end

  // Free bank count reported from the registered bank states.
  always_comb begin
    free_cnt = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_q[b] == FREE) free_cnt = free_cnt + CNT_W'(1);
    end
  end

  assign free_banks = free_cnt;

  // Bank storage is never cleared; the first K-tile overwrite initialises every row.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      for (int c = 0; c < N_COLS; c++) begin
        mem[wr_ptr][ELEM_AW'(row_base + c)] <= wr_row[c];
      end
    end
  end

  // Bank FSMs, pointers, drain sequencing, read stage and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NUM_BANKS; b++) bank_q[b] <= FREE;
      for (int p = 0; p < PACK; p++) rd_word[p] <= '0;
      wr_ptr     <= '0;
      drain_ptr  <= '0;
      reading    <= 1'b0;
      beat_cnt   <= '0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
      rd_bank    <= '0;
      rd_relu    <= 1'b0;
      rd_mult    <= '0;
      rd_shift   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_bank   <= '0;
      acc_ovf    <= 1'b0;
      commit_err <= 1'b0;
    end else begin
      bank_q <= bank_d;
      if (commit_ok) wr_ptr <= next_ptr(wr_ptr);
      if (start) reading <= 1'b1;
      if (issue) begin
        if (issue_last) begin
          beat_cnt  <= '0;
          drain_ptr <= drain_next;
          reading   <= chain;
        end else begin
          beat_cnt <= beat_cnt + BEAT_W'(1);
        end
      end
      if (rd_can) begin
        rd_valid <= issue;
        rd_last  <= issue_last;
        rd_bank  <= drain_ptr;
        rd_word  <= rd_mux;
        rd_relu  <= relu_en;
        rd_mult  <= scale_mult;
        rd_shift <= scale_shift;
      end
      if (out_can) begin
        out_valid <= rd_valid;
        out_last  <= rd_valid && rd_last;
        out_bank  <= rd_bank;
      end
      if (wr_ovf)     acc_ovf    <= 1'b1;
      if (commit_bad) commit_err <= 1'b1;
    end
  end

  for (genvar i = 0; i < PACK; i++) begin : g_lane
    logic signed [OUT_W-1:0] lane_q;
    requant_lane u_lane (
      .clk         (clk),
      .rst         (rst),
      .en          (out_can && rd_valid),
      .acc         (rd_word[i]),
      .relu_en     (rd_relu),
      .scale_mult  (rd_mult),
      .scale_shift (rd_shift),
      .q           (lane_q)
    );
    assign out_data[i*OUT_W +: OUT_W] = lane_q;
  end

endmodule

// File: tb/tb_output_accum_multibank.sv
// Self-checking bench: directed scenarios with random data, checked against an arithmetic model.
module tb_output_accum_multibank;

  localparam int N_ROWS    = 14;
  localparam int N_COLS    = 14;
  localparam int ACC_W     = 32;
  localparam int OUT_W     = 8;
  localparam int NUM_BANKS = 3;
  localparam int PACK      = 8;
  localparam int TOTAL     = N_ROWS * N_COLS;
  localparam int BEATS     = (TOTAL + PACK - 1) / PACK;
  localparam longint AMAX  = (longint'(1) <<< 31) - 1;
  localparam longint AMIN  = -(longint'(1) <<< 31);

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     in_valid;
  logic                     in_ready;
  logic [3:0]               in_row;
  logic                     in_first_k;
  logic [N_COLS*ACC_W-1:0]  in_data;
  logic                     tile_commit;
  logic                     relu_en;
  logic [15:0]              scale_mult;
  logic [4:0]               scale_shift;
  logic                     out_valid;
  logic                     out_ready;
  logic [PACK*OUT_W-1:0]    out_data;
  logic                     out_last;
  logic [2:0]               free_banks;
  logic                     acc_ovf;
  logic                     commit_err;

  output_accum_multibank #(
    .N_ROWS    (N_ROWS),
    .N_COLS    (N_COLS),
    .NUM_BANKS (NUM_BANKS),
    .PACK      (PACK)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_row      (in_row),
    .in_first_k  (in_first_k),
    .in_data     (in_data),
    .tile_commit (tile_commit),
    .relu_en     (relu_en),
    .scale_mult  (scale_mult),
    .scale_shift (scale_shift),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .free_banks  (free_banks),
    .acc_ovf     (acc_ovf),
    .commit_err  (commit_err)
  );

  always #5 clk = ~clk;

  int          tests_run = 0;
  int          failed    = 0;
  logic [63:0] exp_q [$];
  longint      pass_data [3][TOTAL];
  longint      model_acc [TOTAL];
  bit          exp_ovf = 1'b0;
  int          first_cyc;
  int          last_cyc;
  logic [63:0] first_beat;
  logic [63:0] last_beat;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rq(input longint a, input bit relu, input int mult, input int shift);
    longint x;
    longint p;
    longint r;
    x = (relu && a < 0) ? 0 : a;
    p = x * longint'(mult);
    if (shift == 0) r = p;
    else r = (p + (longint'(1) <<< (shift - 1))) >>> shift;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return r[7:0];
  endfunction

  task automatic fill_random(input int passes, input int span);
    for (int p = 0; p < passes; p++)
      for (int e = 0; e < TOTAL; e++)
        pass_data[p][e] = longint'($urandom_range(0, 2 * span)) - longint'(span);
  endtask

  task automatic apply_stimulus(input int row, input bit fk, input int pass, input bit commit);
    int n = 0;
    in_valid    = 1'b1;
    in_row      = 4'(row);
    in_first_k  = fk;
    tile_commit = commit;
    for (int c = 0; c < N_COLS; c++)
      in_data[c*ACC_W +: ACC_W] = (row < N_ROWS) ? 32'(pass_data[pass][row*N_COLS+c]) : $urandom;
    while (!in_ready && n < 500) begin
      step();
      n++;
    end
    if (!in_ready) check_output("in_ready_timeout", {63'd0, in_ready}, 64'd1);
    step();
    if (row < N_ROWS) begin
      for (int c = 0; c < N_COLS; c++) begin
        int e;
        longint s;
        e = row * N_COLS + c;
        if (fk) begin
          model_acc[e] = pass_data[pass][e];
        end else begin
          s = model_acc[e] + pass_data[pass][e];
          if (s > AMAX) begin s = AMAX; exp_ovf = 1'b1; end
          if (s < AMIN) begin s = AMIN; exp_ovf = 1'b1; end
          model_acc[e] = s;
        end
      end
    end
    in_valid    = 1'b0;
    tile_commit = 1'b0;
  endtask

  task automatic load_tile(input int passes, input bit junk, input bit sep_commit);
    logic [63:0] w;
    for (int p = 0; p < passes; p++) begin
      if (junk) apply_stimulus(N_ROWS + int'($urandom_range(0, 1)), 1'b0, p, 1'b0);
      for (int r = 0; r < N_ROWS; r++) begin
        if ($urandom_range(0, 3) == 0) step();
        apply_stimulus(r, p == 0, p, (p == passes - 1) && (r == N_ROWS - 1) && !sep_commit);
      end
    end
    if (sep_commit) begin
      tile_commit = 1'b1;
      step();
      tile_commit = 1'b0;
    end
    for (int b = 0; b < BEATS; b++) begin
      w = '0;
      for (int p = 0; p < PACK; p++) begin
        int e;
        e = b * PACK + p;
        if (e < TOTAL) w[p*8 +: 8] = rq(model_acc[e], relu_en, int'(scale_mult), int'(scale_shift));
      end
      exp_q.push_back(w);
    end
  endtask

  task automatic check_beats(input int nbanks, input bit rand_ready);
    int          got = 0;
    int          cyc = 0;
    bit          held = 1'b0;
    bit          rdy;
    logic [63:0] held_data = '0;
    logic [63:0] exp;
    first_cyc = -1;
    last_cyc  = -1;
    while (got < nbanks * BEATS && cyc < 5000) begin
      rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rdy;
      if (held) begin
        check_output("stall_valid", {63'd0, out_valid}, 64'd1);
        check_output("stall_data", out_data, held_data);
      end
      if (out_valid && first_cyc < 0) first_cyc = cyc;
      if (out_valid && rdy) begin
        exp = exp_q.pop_front();
        check_output("beat_data", out_data, exp);
        check_output("beat_last", {63'd0, out_last}, {63'd0, (got % BEATS) == BEATS - 1});
        if (got == 0) first_beat = out_data;
        last_beat = out_data;
        last_cyc  = cyc;
        got++;
      end
      held      = out_valid && !rdy;
      held_data = out_data;
      step();
      cyc++;
    end
    out_ready = 1'b0;
    if (got < nbanks * BEATS) check_output("drain_timeout", 64'(got), 64'(nbanks * BEATS));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_row = '0; in_first_k = 1'b0; in_data = '0;
    tile_commit = 1'b0; relu_en = 1'b0; scale_mult = 16'd1; scale_shift = 5'd0; out_ready = 1'b0;
    repeat (3) step();
    check_output("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_output("rst_out_last", {63'd0, out_last}, 64'd0);
    check_output("rst_out_data", out_data, 64'd0);
    check_output("rst_free_banks", 64'(free_banks), 64'd3);
    check_output("rst_acc_ovf", {63'd0, acc_ovf}, 64'd0);
    check_output("rst_commit_err", {63'd0, commit_err}, 64'd0);
    check_output("rst_in_ready", {63'd0, in_ready}, 64'd1);
    rst = 1'b0;
    step();

    // Three K-passes of all-ones rows: every element 3, tail lanes zero.
    for (int p = 0; p < 3; p++) for (int e = 0; e < TOTAL; e++) pass_data[p][e] = 1;
    load_tile(3, 1'b0, 1'b0);
    check_beats(1, 1'b0);
    check_output("ones_latency", 64'(first_cyc), 64'd3);
    check_output("ones_span", 64'(last_cyc - first_cyc), 64'(BEATS - 1));
    check_output("ones_first", first_beat, 64'h0303030303030303);
    check_output("ones_last", last_beat, 64'h0000000003030303);
    check_output("ones_free", 64'(free_banks), 64'd3);
    check_output("ones_no_ovf", {63'd0, acc_ovf}, 64'd0);

    // Saturating accumulation into element 0.
    fill_random(2, 1000);
    pass_data[0][0] = 64'h7FFFFFF0;
    pass_data[1][0] = 64'h20;
    load_tile(2, 1'b1, 1'b1);
    check_output("sat_acc_ovf", {63'd0, acc_ovf}, 64'd1);
    check_output("sat_model_ovf", {63'd0, acc_ovf}, {63'd0, exp_ovf});
    check_beats(1, 1'b0);
    check_output("sat_out127", 64'(first_beat[7:0]), 64'h7F);

    // ReLU on, unit scale.
    fill_random(1, 1000);
    pass_data[0][1] = -300;
    pass_data[0][2] = 5;
    relu_en = 1'b1;
    load_tile(1, 1'b0, 1'b0);
    check_beats(1, 1'b0);
    check_output("relu_neg", 64'(first_beat[15:8]), 64'h00);
    check_output("relu_pos", 64'(first_beat[23:16]), 64'h05);

    // ReLU off, shift 1: -300 -> -150 -> -128, 5 -> 3.
    relu_en = 1'b0;
    scale_shift = 5'd1;
    load_tile(1, 1'b0, 1'b0);
    check_beats(1, 1'b0);
    check_output("shift_neg_sat", 64'(first_beat[15:8]), 64'h80);
    check_output("shift_round", 64'(first_beat[23:16]), 64'h03);

    // Random data and scaling with random back-pressure.
    for (int t = 0; t < 2; t++) begin
      relu_en     = 1'($urandom_range(0, 1));
      scale_mult  = 16'($urandom_range(1, 300));
      scale_shift = 5'($urandom_range(0, 12));
      fill_random(2, 100000);
      load_tile(2, 1'b1, 1'b0);
      check_beats(1, 1'b1);
      check_output("rand_free", 64'(free_banks), 64'd3);
    end

    // Fill all banks while the drain is blocked, then release.
    relu_en = 1'b0; scale_mult = 16'd3; scale_shift = 5'd2;
    for (int t = 0; t < 3; t++) begin
      fill_random(2, 2000);
      load_tile(2, 1'b0, 1'b0);
    end
    check_output("full_in_ready", {63'd0, in_ready}, 64'd0);
    check_output("full_free", 64'(free_banks), 64'd0);
    check_beats(3, 1'b0);
    check_output("full_no_bubble", 64'(last_cyc - first_cyc), 64'(3 * BEATS - 1));
    check_output("full_free_after", 64'(free_banks), 64'd3);
    check_output("full_in_ready_after", {63'd0, in_ready}, 64'd1);

    // Commit with no accumulating bank.
    tile_commit = 1'b1;
    step();
    tile_commit = 1'b0;
    check_output("cerr_flag", {63'd0, commit_err}, 64'd1);
    check_output("cerr_free", 64'(free_banks), 64'd3);
    check_output("cerr_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (4) step();
    check_output("cerr_no_valid", {63'd0, out_valid}, 64'd0);

    // Reset in the middle of a drain.
    scale_mult = 16'd1; scale_shift = 5'd0;
    fill_random(1, 100);
    load_tile(1, 1'b0, 1'b0);
    out_ready = 1'b1;
    repeat (8) step();
    check_output("mid_valid", {63'd0, out_valid}, 64'd1);
    rst = 1'b1;
    step();
    check_output("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    check_output("mid_rst_last", {63'd0, out_last}, 64'd0);
    check_output("mid_rst_data", out_data, 64'd0);
    check_output("mid_rst_free", 64'(free_banks), 64'd3);
    check_output("mid_rst_cerr", {63'd0, commit_err}, 64'd0);
    check_output("mid_rst_ovf", {63'd0, acc_ovf}, 64'd0);
    rst = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    step();

    // Clean operation after the abort.
    relu_en     = 1'($urandom_range(0, 1));
    scale_mult  = 16'($urandom_range(1, 50));
    scale_shift = 5'($urandom_range(0, 6));
    fill_random(2, 5000);
    load_tile(2, 1'b0, 1'b0);
    check_beats(1, 1'b1);
    check_output("post_rst_free", 64'(free_banks), 64'd3);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
